// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI bus arbiter: FSM state encodings, timing defaults
// and a small wrap-around helper used for the round-robin pointer.
package spi_arb_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_NCS      = 4;
    localparam int DEF_LEN_W    = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_GAP   = 3;

    // Width of the shared SETUP/HOLD/GAP cycle counter.
    localparam int TCNT_W = 8;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after ptr, wrapping.
module spi_rr_pick
    import spi_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int PTR_W = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0]  mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [NREQ-1:0]  onehot,
    output logic [PTR_W-1:0] idx
);

    int               cand;
    logic [PTR_W-1:0] cand_w;

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        cand   = 0;
        cand_w = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_w = PTR_W'(cand);
            if (!valid && mask[cand_w]) begin
                valid = 1'b1;
                idx   = cand_w;
            end
        end
    end

    assign onehot = valid ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one byte-level SPI master engine between NREQ requesters, round-robin,
// owning the slave chip select for the whole multi-byte transaction.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int NCS      = DEF_NCS,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_GAP   = DEF_CS_GAP
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ*$clog2(NCS)-1:0] req_cs,
    input  logic [NREQ*LEN_W-1:0]       req_len,
    input  logic [NREQ*8-1:0]           req_tx,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             byte_ack,
    output logic                        rx_valid,
    output logic [7:0]                  rx_byte,
    output logic [NCS-1:0]              cs_n,
    output logic                        eng_start,
    output logic [7:0]                  eng_tx,
    input  logic                        eng_busy,
    input  logic                        eng_done,
    input  logic [7:0]                  eng_rx,
    output logic [2:0]                  fsm_state
);

    // Engine handshake: eng_start is a registered 1-cycle pulse issued only when
    // eng_busy was low; eng_tx holds until the matching eng_done pulse, which is
    // only honoured in WAIT. byte_ack pulses with eng_start so the owner can
    // present its next byte; rx_valid pulses the cycle after eng_done.

    localparam int CS_W  = $clog2(NCS);
    localparam int PTR_W = $clog2(NREQ);

    localparam logic [TCNT_W-1:0] SETUP_LAST = TCNT_W'(CS_SETUP - 1);
    localparam logic [TCNT_W-1:0] HOLD_LAST  = TCNT_W'(CS_HOLD - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(CS_GAP - 1);

    logic [2:0]        state;
    logic [PTR_W-1:0]  owner;
    logic [PTR_W-1:0]  rr_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [TCNT_W-1:0] tcnt;

    logic [NREQ-1:0]  pick_mask;
    logic [NREQ-1:0]  pick_onehot;
    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [CS_W-1:0]  pick_cs;
    logic [LEN_W-1:0] pick_len;
    logic [7:0]       sel_tx;
    logic [NCS-1:0]   cs_dec;

    // Zero-length requests are masked out so they can never win arbitration.
    always_comb begin
        pick_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            pick_mask[i] = req[i] && (req_len[i*LEN_W +: LEN_W] != '0);
        end
    end

    spi_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .mask   (pick_mask),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_cs  = '0;
        pick_len = '0;
        sel_tx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx == PTR_W'(i)) begin
                pick_cs  = req_cs[i*CS_W +: CS_W];
                pick_len = req_len[i*LEN_W +: LEN_W];
            end
            if (owner == PTR_W'(i)) begin
                sel_tx = req_tx[i*8 +: 8];
            end
        end
    end

    // An out-of-range slave index matches no line, leaving every CS deasserted.
    always_comb begin
        cs_dec = '1;
        for (int j = 0; j < NCS; j++) begin
            if (pick_cs == CS_W'(j)) cs_dec[j] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            tcnt      <= '0;
            gnt       <= '0;
            byte_ack  <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            cs_n      <= '1;
            eng_start <= 1'b0;
            eng_tx    <= '0;
        end else begin
            eng_start <= 1'b0;
            byte_ack  <= '0;
            rx_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        gnt       <= pick_onehot;
                        cs_n      <= cs_dec;
                        remaining <= pick_len;
                        tcnt      <= '0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tcnt == SETUP_LAST) begin
                        tcnt  <= '0;
                        state <= ST_START;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_START: begin
                    if (!eng_busy) begin
                        eng_start <= 1'b1;
                        eng_tx    <= sel_tx;
                        byte_ack  <= gnt;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        rx_byte   <= eng_rx;
                        rx_valid  <= 1'b1;
                        remaining <= remaining - 1'b1;
                        tcnt      <= '0;
                        state     <= (remaining == LEN_W'(1)) ? ST_HOLD : ST_START;
                    end
                end
                // CS stays low for CS_HOLD full cycles after the cycle carrying the last eng_done.
                ST_HOLD: begin
                    if (tcnt == HOLD_LAST) begin
                        cs_n   <= '1;
                        gnt    <= '0;
                        rr_ptr <= PTR_W'(wrap_inc(32'(owner), NREQ));
                        tcnt   <= '0;
                        state  <= ST_GAP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tcnt == GAP_LAST) begin
                        tcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a fixed-latency echoing engine model.
module tb_spi_bus_arbiter;
    import spi_arb_pkg::*;

    localparam int NREQ     = 4;
    localparam int NCS      = 4;
    localparam int LEN_W    = 4;
    localparam int CS_W     = 2;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 3;
    localparam int ENG_LAT  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*CS_W-1:0]  req_cs;
    logic [NREQ*LEN_W-1:0] req_len;
    logic [NREQ*8-1:0]     req_tx;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       byte_ack;
    logic                  rx_valid;
    logic [7:0]            rx_byte;
    logic [NCS-1:0]        cs_n;
    logic                  eng_start;
    logic [7:0]            eng_tx;
    logic                  eng_busy;
    logic                  eng_done = 1'b0;
    logic [7:0]            eng_rx = 8'h00;
    logic [2:0]            fsm_state;
    logic                  force_busy;

    spi_bus_arbiter #(
        .NREQ(NREQ), .NCS(NCS), .LEN_W(LEN_W),
        .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_cs(req_cs), .req_len(req_len),
        .req_tx(req_tx), .gnt(gnt), .byte_ack(byte_ack), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .cs_n(cs_n), .eng_start(eng_start), .eng_tx(eng_tx),
        .eng_busy(eng_busy), .eng_done(eng_done), .eng_rx(eng_rx), .fsm_state(fsm_state)
    );

    // ---------------- engine model: echoes eng_tx after ENG_LAT cycles ----------------
    int         eng_cnt = 0;
    logic [7:0] eng_shift = 8'h00;
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_rx   <= eng_shift;
            end
        end else if (eng_start) begin
            eng_cnt   <= ENG_LAT;
            eng_shift <= eng_tx;
        end
    end
    assign eng_busy = (eng_cnt != 0) || force_busy;

    // ---------------- requester byte sources ----------------
    logic [7:0] tx_base [NREQ];
    int         ack_total [NREQ];
    int         ack_base [NREQ];
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_tx[i*8 +: 8] = tx_base[i] + 8'(8'h11 * (ack_total[i] - ack_base[i]));
        end
    end

    // ---------------- monitor ----------------
    int         start_log[$];
    int         done_log[$];
    int         gnt_log[$];
    int         gnt_cyc_log[$];
    int         cs_high_log[$];
    int         gap_log[$];
    logic [7:0] rx_log[$];
    int         cs_low_total [NCS];
    int         high_run = 0;
    int         onehot_err = 0;
    logic       cs_prev_high = 1'b1;
    logic [NREQ-1:0] gnt_prev = '0;

    initial begin
        for (int i = 0; i < NREQ; i++) ack_total[i] = 0;
        for (int j = 0; j < NCS; j++) cs_low_total[j] = 0;
    end

    always @(negedge clk) begin
        if (eng_start) start_log.push_back(cyc);
        if (eng_done) done_log.push_back(cyc);
        if (rx_valid) rx_log.push_back(rx_byte);
        for (int i = 0; i < NREQ; i++) if (byte_ack[i]) ack_total[i] = ack_total[i] + 1;
        for (int j = 0; j < NCS; j++) if (cs_n[j] == 1'b0) cs_low_total[j] = cs_low_total[j] + 1;
        if (gnt != '0 && gnt_prev == '0) begin
            gnt_cyc_log.push_back(cyc);
            for (int i = 0; i < NREQ; i++) if (gnt[i]) gnt_log.push_back(i);
        end
        if (&cs_n) begin
            if (!cs_prev_high) cs_high_log.push_back(cyc);
            high_run = high_run + 1;
        end else begin
            if (cs_prev_high) gap_log.push_back(high_run);
            high_run = 0;
        end
        cs_prev_high = &cs_n;
        gnt_prev     = gnt;
        if (!$onehot0(gnt) || !$onehot0(~cs_n)) onehot_err = onehot_err + 1;
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         rx_rd = 0;
    int         n_vec = 0;
    int         n_bad = 0;
    int s_start, s_done, s_gnt, s_cs_high, s_gap;
    int low_base [NCS];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qv(input int q[$], input int i);
        return (i >= 0 && i < q.size()) ? q[i] : -1000;
    endfunction

    task automatic check_rx(input string tag);
        while (rx_rd < rx_log.size()) begin
            if (exp_q.size() == 0) check_eq({tag, "_extra"}, 32'(rx_log[rx_rd]), 32'hffff_ffff);
            else check_eq(tag, 32'(rx_log[rx_rd]), 32'(exp_q.pop_front()));
            rx_rd++;
        end
        check_eq({tag, "_left"}, exp_q.size(), 0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic start_test();
        s_start   = start_log.size();
        s_done    = done_log.size();
        s_gnt     = gnt_log.size();
        s_cs_high = cs_high_log.size();
        s_gap     = gap_log.size();
        for (int i = 0; i < NREQ; i++) ack_base[i] = ack_total[i];
        for (int j = 0; j < NCS; j++) low_base[j] = cs_low_total[j];
    endtask

    task automatic set_req(input int i, input int cs, input int len, input logic [7:0] base);
        req_cs[i*CS_W +: CS_W]    = CS_W'(cs);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
        tx_base[i]                = base;
    endtask

    task automatic wait_grant(input int who, input int budget, output int at);
        at = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt[who]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check_eq("grant_timeout", 32'(gnt), 32'(1 << who));
    endtask

    task automatic wait_release(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt == '0) return;
        end
        check_eq("release_timeout", 32'(gnt), 0);
    endtask

    task automatic wait_grants(input int count, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt_log.size() - s_gnt >= count) return;
        end
        check_eq("grants_timeout", gnt_log.size() - s_gnt, count);
    endtask

    // ---------------- stimulus ----------------
    int g;
    int c0;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        req = '0; req_cs = '0; req_len = '0; force_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            tx_base[i]  = 8'h00;
            ack_base[i] = 0;
        end
        rst = 1'b1;
        tick(3);

        check_eq("rst_gnt", 32'(gnt), 0);
        check_eq("rst_cs_n", 32'(cs_n), 32'hf);
        check_eq("rst_eng_start", 32'(eng_start), 0);
        check_eq("rst_eng_tx", 32'(eng_tx), 0);
        check_eq("rst_rx_valid", 32'(rx_valid), 0);
        check_eq("rst_rx_byte", 32'(rx_byte), 0);
        check_eq("rst_byte_ack", 32'(byte_ack), 0);
        check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(2);

        // 1: single 3-byte transaction to slave 2
        start_test();
        set_req(0, 2, 3, 8'hA1);
        exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        c0 = cyc;
        req[0] = 1'b1;
        wait_grant(0, 10, g);
        req[0] = 1'b0;
        wait_release(100);
        tick(2);
        check_eq("t1_gnt_latency", g - c0, 1);
        check_eq("t1_starts", start_log.size() - s_start, 3);
        check_eq("t1_acks", ack_total[0] - ack_base[0], 3);
        check_eq("t1_setup", qv(start_log, s_start) - g, CS_SETUP + 1);
        check_eq("t1_restart", qv(start_log, s_start + 1) - qv(done_log, s_done), 2);
        check_eq("t1_hold", qv(cs_high_log, s_cs_high) - qv(done_log, s_done + 2), CS_HOLD + 1);
        check_eq("t1_cs2_low", cs_low_total[2] - low_base[2], 25);
        check_eq("t1_cs_other", (cs_low_total[0] - low_base[0]) + (cs_low_total[1] - low_base[1])
                 + (cs_low_total[3] - low_base[3]), 0);
        check_eq("t1_gnt_len", qv(cs_high_log, s_cs_high) - g, 25);
        check_rx("t1_rx");

        // 2: all four requesting, one byte each -> 0,1,2,3,0
        do_reset();
        start_test();
        for (int i = 0; i < NREQ; i++) set_req(i, i, 1, 8'(8'h10 * (i + 1)));
        exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
        exp_q.push_back(8'h40); exp_q.push_back(8'h21);
        req = '1;
        wait_grants(5, 300);
        req = '0;
        wait_release(100);
        tick(8);
        check_eq("t2_grants", gnt_log.size() - s_gnt, 5);
        for (int k = 0; k < 5; k++) check_eq($sformatf("t2_order%0d", k), qv(gnt_log, s_gnt + k), order[k]);
        for (int k = 1; k < 5; k++) check_eq($sformatf("t2_gap%0d", k), qv(gap_log, s_gap + k), CS_GAP + 1);
        check_rx("t2_rx");

        // 3: owner drops req after first byte; all 4 bytes still run
        start_test();
        set_req(0, 1, 4, 8'h90);
        exp_q.push_back(8'h90); exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
        req[0] = 1'b1;
        wait_grant(0, 20, g);
        for (int c = 0; c < 50 && (ack_total[0] - ack_base[0]) < 1; c++) tick(1);
        req[0] = 1'b0;
        wait_release(200);
        tick(12);
        check_eq("t3_starts", start_log.size() - s_start, 4);
        check_eq("t3_acks", ack_total[0] - ack_base[0], 4);
        check_eq("t3_grants", gnt_log.size() - s_gnt, 1);
        check_eq("t3_cs1_low", cs_low_total[1] - low_base[1], 32);
        check_rx("t3_rx");

        // 4: engine busy stalls START for 5 cycles
        start_test();
        set_req(2, 3, 1, 8'hC0);
        exp_q.push_back(8'hC0);
        req[2] = 1'b1;
        wait_grant(2, 20, g);
        req[2] = 1'b0;
        force_busy = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick(1);
            check_eq($sformatf("t4_stall_start%0d", n), 32'(eng_start), 0);
            check_eq($sformatf("t4_stall_ack%0d", n), 32'(byte_ack), 0);
            if (n == 7) force_busy = 1'b0;
        end
        wait_release(100);
        tick(6);
        check_eq("t4_delay", qv(start_log, s_start) - g, CS_SETUP + 1 + 5);
        check_eq("t4_acks", ack_total[2] - ack_base[2], 1);
        check_rx("t4_rx");

        // 5: reset during WAIT of byte 2, then arbitration restarts at 0
        start_test();
        set_req(3, 0, 3, 8'h50);
        exp_q.push_back(8'h50);
        req[3] = 1'b1;
        wait_grant(3, 20, g);
        for (int c = 0; c < 100 && (start_log.size() - s_start) < 2; c++) tick(1);
        rst = 1'b1;
        req[3] = 1'b0;
        tick(1);
        check_eq("t5_cs_n", 32'(cs_n), 32'hf);
        check_eq("t5_gnt", 32'(gnt), 0);
        check_eq("t5_state", 32'(fsm_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick(12);
        check_rx("t5_rx_pre");
        start_test();
        set_req(0, 1, 1, 8'h60);
        set_req(3, 2, 1, 8'h70);
        exp_q.push_back(8'h60); exp_q.push_back(8'h70);
        req[0] = 1'b1;
        req[3] = 1'b1;
        wait_grants(2, 200);
        req = '0;
        wait_release(100);
        tick(8);
        check_eq("t5_first", qv(gnt_log, s_gnt), 0);
        check_eq("t5_second", qv(gnt_log, s_gnt + 1), 3);
        check_rx("t5_rx_post");

        // 6: zero-length request is skipped, the other is served
        start_test();
        set_req(1, 0, 0, 8'hEE);
        set_req(2, 1, 2, 8'h80);
        exp_q.push_back(8'h80); exp_q.push_back(8'h91);
        req[1] = 1'b1;
        req[2] = 1'b1;
        wait_grant(2, 20, g);
        req[2] = 1'b0;
        wait_release(100);
        tick(20);
        req[1] = 1'b0;
        check_eq("t6_grants", gnt_log.size() - s_gnt, 1);
        check_eq("t6_owner", qv(gnt_log, s_gnt), 2);
        check_eq("t6_req1_acks", ack_total[1] - ack_base[1], 0);
        check_rx("t6_rx");

        check_eq("onehot", onehot_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
